// File: rtl/plic_reg_arbiter.sv
// plic_reg_arbiter
// Shares the single PLIC register bus port between N_MASTER requesters.
// Only one transaction is in flight at a time. The grant is held until the
// PLIC answers or the timeout fires. This keeps a claim read, which has a side
// effect on the gateway, from ever being duplicated or interleaved.
//
// Ports
//   clk_i, rst_i      clock (rising edge), asynchronous active-high reset
//   mst_valid_i       per-master request valid, held until that master's ready
//   mst_write_i       per-master write flag (1 = write, 0 = read)
//   mst_addr_i        per-master address, master 0 at the LSBs
//   mst_wdata_i       per-master write data
//   mst_wstrb_i       per-master byte strobes
//   mst_ready_o       per-master completion pulse (at most one bit set)
//   mst_rdata_o       shared read data, valid only with a ready bit, else 0
//   mst_error_o       per-master error, qualified by ready
//   slv_valid_o       request valid to the PLIC
//   slv_write_o       write flag to the PLIC
//   slv_addr_o        address to the PLIC
//   slv_wdata_o       write data to the PLIC
//   slv_wstrb_o       byte strobes to the PLIC
//   slv_ready_i       PLIC completion (may depend combinationally on slv_valid_o)
//   slv_rdata_i       PLIC read data
//   slv_error_i       PLIC error
//   busy_o            high while a transaction is in flight
//   grant_o           currently or most recently granted master index
module plic_reg_arbiter #(
  parameter int            N_MASTER = 2,
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            TIMEOUT  = 255,
  parameter logic [DW-1:0] ERR_DATA = DW'(32'hBADC0DE5)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_MASTER-1:0]      mst_valid_i,
  input  logic [N_MASTER-1:0]      mst_write_i,
  input  logic [N_MASTER*AW-1:0]   mst_addr_i,
  input  logic [N_MASTER*DW-1:0]   mst_wdata_i,
  input  logic [N_MASTER*DW/8-1:0] mst_wstrb_i,
  output logic [N_MASTER-1:0]      mst_ready_o,
  output logic [DW-1:0]            mst_rdata_o,
  output logic [N_MASTER-1:0]      mst_error_o,
  output logic                     slv_valid_o,
  output logic                     slv_write_o,
  output logic [AW-1:0]            slv_addr_o,
  output logic [DW-1:0]            slv_wdata_o,
  output logic [DW/8-1:0]          slv_wstrb_o,
  input  logic                     slv_ready_i,
  input  logic [DW-1:0]            slv_rdata_i,
  input  logic                     slv_error_i,
  output logic                     busy_o,
  output logic [((N_MASTER > 1) ? $clog2(N_MASTER) : 1)-1:0] grant_o
);

  localparam int GW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam int SW = DW / 8;
  // The counter only has to reach TIMEOUT-1; the timeout fires on that value.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t        r_state, w_state_next;
  logic [GW-1:0] r_g, w_g_next;
  logic [GW-1:0] r_ptr, w_ptr_next;
  logic [TW-1:0] r_tcnt, w_tcnt_next;

  logic          w_any;
  logic [GW-1:0] w_sel;
  logic          w_busy;
  logic          w_g_valid;
  logic          w_done;
  logic          w_timeout;
  logic [GW-1:0] w_g_inc;

  // Per-master views of the packed request buses.
  logic [AW-1:0] w_addr  [N_MASTER];
  logic [DW-1:0] w_wdata [N_MASTER];
  logic [SW-1:0] w_wstrb [N_MASTER];

  generate
    for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_unpack
      assign w_addr[gi]  = mst_addr_i[gi*AW +: AW];
      assign w_wdata[gi] = mst_wdata_i[gi*DW +: DW];
      assign w_wstrb[gi] = mst_wstrb_i[gi*SW +: SW];
    end
  endgenerate

  // Round-robin pick: first asserted valid scanning ptr, ptr+1, ... mod N.
  always_comb begin
    int idx;
    w_any = 1'b0;
    w_sel = '0;
    idx   = 0;
    for (int i = 0; i < N_MASTER; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= N_MASTER) begin
        idx = idx - N_MASTER;
      end
      if (!w_any && mst_valid_i[idx]) begin
        w_any = 1'b1;
        w_sel = GW'(idx);
      end
    end
  end

  assign w_busy    = (r_state == S_BUSY);
  assign w_g_valid = mst_valid_i[r_g];
  // A slave response in the timeout cycle wins, so timeout requires !ready.
  assign w_done    = w_busy && w_g_valid && slv_ready_i;
  assign w_timeout = (TIMEOUT != 0) && w_busy && w_g_valid && !slv_ready_i &&
                     (r_tcnt == TLAST);
  assign w_g_inc   = (r_g == GW'(N_MASTER - 1)) ? '0 : r_g + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_g     <= '0;
      r_ptr   <= '0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_g     <= w_g_next;
      r_ptr   <= w_ptr_next;
      r_tcnt  <= w_tcnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_g_next     = r_g;
    w_ptr_next   = r_ptr;
    w_tcnt_next  = r_tcnt;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_g_next     = w_sel;
          w_tcnt_next  = '0;
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!w_g_valid) begin
          // Requester abandoned its transaction: release without moving ptr.
          w_state_next = S_IDLE;
        end else if (w_done || w_timeout) begin
          w_state_next = S_IDLE;
          w_ptr_next   = w_g_inc;
        end else if (r_tcnt != '1) begin
          w_tcnt_next = r_tcnt + 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    mst_ready_o = '0;
    mst_error_o = '0;
    mst_rdata_o = '0;
    slv_valid_o = w_busy && w_g_valid;
    slv_write_o = 1'b0;
    slv_addr_o  = '0;
    slv_wdata_o = '0;
    slv_wstrb_o = '0;
    if (w_busy) begin
      slv_write_o = mst_write_i[r_g];
      slv_addr_o  = w_addr[r_g];
      slv_wdata_o = w_wdata[r_g];
      slv_wstrb_o = w_wstrb[r_g];
    end
    if (w_done) begin
      mst_ready_o[r_g] = 1'b1;
      mst_error_o[r_g] = slv_error_i;
      mst_rdata_o      = slv_rdata_i;
    end else if (w_timeout) begin
      mst_ready_o[r_g] = 1'b1;
      mst_error_o[r_g] = 1'b1;
      mst_rdata_o      = ERR_DATA;
    end
  end

  assign busy_o  = w_busy;
  assign grant_o = r_g;

endmodule

// File: tb/tb_plic_reg_arbiter.sv
// tb_plic_reg_arbiter
// Scoreboard bench: the driver predicts each transaction's grant order and
// response at request time and queues it; a negedge monitor compares whenever
// the arbiter is busy or pulses a ready bit. A slave model answers with a
// per-transaction planned latency.
module tb_plic_reg_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 4;
  localparam logic [31:0] ERRD = 32'hBADC0DE5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [N-1:0]    m_valid = '0;
  logic [N-1:0]    m_write = '0;
  logic [N*AW-1:0] m_addr  = '0;
  logic [N*DW-1:0] m_wdata = '0;
  logic [N*SW-1:0] m_wstrb = '0;

  logic [N-1:0]    mst_ready_o;
  logic [DW-1:0]   mst_rdata_o;
  logic [N-1:0]    mst_error_o;
  logic            slv_valid_o;
  logic            slv_write_o;
  logic [AW-1:0]   slv_addr_o;
  logic [DW-1:0]   slv_wdata_o;
  logic [SW-1:0]   slv_wstrb_o;
  logic            slv_ready_i = 1'b0;
  logic [DW-1:0]   slv_rdata_i = '0;
  logic            slv_error_i = 1'b0;
  logic            busy_o;
  logic [0:0]      grant_o;

  plic_reg_arbiter #(
    .N_MASTER(N), .AW(AW), .DW(DW), .TIMEOUT(TO), .ERR_DATA(ERRD)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .mst_valid_i(m_valid), .mst_write_i(m_write), .mst_addr_i(m_addr),
    .mst_wdata_i(m_wdata), .mst_wstrb_i(m_wstrb),
    .mst_ready_o(mst_ready_o), .mst_rdata_o(mst_rdata_o), .mst_error_o(mst_error_o),
    .slv_valid_o(slv_valid_o), .slv_write_o(slv_write_o), .slv_addr_o(slv_addr_o),
    .slv_wdata_o(slv_wdata_o), .slv_wstrb_o(slv_wstrb_o),
    .slv_ready_i(slv_ready_i), .slv_rdata_i(slv_rdata_i), .slv_error_i(slv_error_i),
    .busy_o(busy_o), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          m;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    bit          err;
    int          cycles;
  } exp_t;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    bit          err;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];

  int n_checks  = 0;
  int n_errors  = 0;
  bit skip_busy = 1'b0;
  int model_ptr = 0;

  bit          st_write [N];
  logic [31:0] st_addr  [N];
  logic [31:0] st_wdata [N];
  logic [3:0]  st_strb  [N];
  int          st_lat   [N];
  logic [31:0] st_rdata [N];
  bit          st_err   [N];
  bit          pend     [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_slv_valid"}, 32'(slv_valid_o), 0);
    chk({tag, "_slv_write"}, 32'(slv_write_o), 0);
    chk({tag, "_slv_addr"},  slv_addr_o, 0);
    chk({tag, "_slv_wdata"}, slv_wdata_o, 0);
    chk({tag, "_slv_wstrb"}, 32'(slv_wstrb_o), 0);
    chk({tag, "_ready"},     32'(mst_ready_o), 0);
    chk({tag, "_error"},     32'(mst_error_o), 0);
    chk({tag, "_rdata"},     mst_rdata_o, 0);
    chk({tag, "_busy"},      32'(busy_o), 0);
    chk({tag, "_grant"},     32'(grant_o), 0);
  endtask

  task automatic stage(input int i, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input int lat, input logic [31:0] rdata, input bit err);
    st_write[i] = wr;
    st_addr[i]  = addr;
    st_wdata[i] = wdata;
    st_strb[i]  = strb;
    st_lat[i]   = lat;
    st_rdata[i] = rdata;
    st_err[i]   = err;
  endtask

  task automatic stage_rand(input int i);
    stage(i, 1'($urandom_range(0, 1)), 32'h0C00_0000 | ($urandom & 32'h03FF_FFFC),
          $urandom, 4'($urandom), $urandom_range(0, 5), $urandom,
          ($urandom_range(0, 3) == 0));
  endtask

  // Reference model: requests raised together are served in cyclic order
  // starting at the pointer; afterwards the pointer sits just past the last one.
  task automatic launch(input logic [N-1:0] mask);
    int    last;
    exp_t  e;
    plan_t p;
    last = model_ptr;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (model_ptr + k) % N;
      if (mask[i]) begin
        e.m = i; e.wr = st_write[i]; e.addr = st_addr[i];
        e.wdata = st_wdata[i]; e.strb = st_strb[i];
        if (st_lat[i] < TO) begin
          e.rdata = st_rdata[i]; e.err = st_err[i]; e.cycles = st_lat[i] + 1;
        end else begin
          e.rdata = ERRD; e.err = 1'b1; e.cycles = TO;
        end
        exp_q.push_back(e);
        p.lat = st_lat[i]; p.rdata = st_rdata[i]; p.err = st_err[i];
        plan_q.push_back(p);
        last = i;
      end
    end
    model_ptr = (last + 1) % N;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        m_write[i]          = st_write[i];
        m_addr[i*AW +: AW]  = st_addr[i];
        m_wdata[i*DW +: DW] = st_wdata[i];
        m_wstrb[i*SW +: SW] = st_strb[i];
        m_valid[i]          = 1'b1;
      end
    end
  endtask

  // Entered and left at posedge+1. A master releases its request at the first
  // posedge+1 after its ready pulse.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++) if (mst_ready_o[i]) pend[i] = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (pend[i]) begin
        m_valid[i] = 1'b0;
        pend[i]    = 1'b0;
      end
    end
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (exp_q.size() == 0 && m_valid == '0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_done: timed out with %0d pending, valid=%b", exp_q.size(), m_valid);
      m_valid = '0;
      exp_q.delete();
      plan_q.delete();
    end
  endtask

  // Slave model: answers a transaction after its planned number of extra cycles.
  bit    s_in  = 1'b0;
  int    s_cnt = 0;
  plan_t s_cur;
  always @(posedge clk) begin
    #2;
    if (!slv_valid_o) begin
      s_in        = 1'b0;
      slv_ready_i = 1'b0;
      slv_rdata_i = $urandom;
      slv_error_i = 1'($urandom);
    end else begin
      if (!s_in) begin
        if (plan_q.size() > 0) s_cur = plan_q.pop_front();
        else begin s_cur.lat = 1000; s_cur.rdata = '0; s_cur.err = 1'b0; end
        s_in  = 1'b1;
        s_cnt = 0;
      end else begin
        s_cnt++;
      end
      if (s_cnt == s_cur.lat) begin
        slv_ready_i = 1'b1;
        slv_rdata_i = s_cur.rdata;
        slv_error_i = s_cur.err;
      end else begin
        slv_ready_i = 1'b0;
        slv_rdata_i = $urandom;
        slv_error_i = 1'($urandom);
      end
    end
  end

  // Monitor / scoreboard.
  int   mon_cnt = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    assert ($onehot0(mst_ready_o)) else begin
      n_errors++;
      $display("FAIL ready_onehot: got %b expected at most one bit", mst_ready_o);
    end
    if (busy_o && !skip_busy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_busy", 32'(busy_o), 0);
      end else begin
        mon_e = exp_q[0];
        chk("slv_valid_busy", 32'(slv_valid_o), 1);
        if (mon_cnt == 0) begin
          chk("grant", 32'(grant_o), 32'(mon_e.m));
          chk("slv_write", 32'(slv_write_o), 32'(mon_e.wr));
          chk("slv_addr", slv_addr_o, mon_e.addr);
          chk("slv_wdata", slv_wdata_o, mon_e.wdata);
          chk("slv_wstrb", 32'(slv_wstrb_o), 32'(mon_e.strb));
        end
        if (mst_ready_o != '0) begin
          logic [N-1:0] er, ee;
          er = '0; ee = '0;
          er[mon_e.m] = 1'b1;
          ee[mon_e.m] = mon_e.err;
          void'(exp_q.pop_front());
          chk("ready_bits", 32'(mst_ready_o), 32'(er));
          chk("rdata", mst_rdata_o, mon_e.rdata);
          chk("error_bits", 32'(mst_error_o), 32'(ee));
          chk("busy_cycles", mon_cnt + 1, mon_e.cycles);
          $display("txn m%0d %s addr=%h rdata=%h err=%0d cycles=%0d", mon_e.m,
                   mon_e.wr ? "WR" : "RD", mon_e.addr, mst_rdata_o, mst_error_o[mon_e.m],
                   mon_cnt + 1);
          mon_cnt = 0;
        end else begin
          chk("idle_rdata", mst_rdata_o, 0);
          chk("idle_error", 32'(mst_error_o), 0);
          mon_cnt++;
        end
      end
    end else begin
      mon_cnt = 0;
      chk("no_ready", 32'(mst_ready_o), 0);
      chk("no_rdata", mst_rdata_o, 0);
      chk("no_error", 32'(mst_error_o), 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    plan_t p;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    #3;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single read, slave ready in the first BUSY cycle.
    stage(0, 1'b0, 32'h0C20_0004, 32'h0, 4'h0, 0, 32'h5, 1'b0);
    launch(2'b01);
    @(negedge clk);
    chk("lat_idle_slv_valid", 32'(slv_valid_o), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("lat_busy_slv_valid", 32'(slv_valid_o), 1);
    chk("single_ready", 32'(mst_ready_o), 32'h1);
    chk("single_rdata", mst_rdata_o, 32'h5);
    @(posedge clk);
    #1;
    m_valid[0] = 1'b0;
    wait_done();

    // Contention, then fairness (master 1 alone, then both).
    repeat (2) begin
      stage_rand(0); stage_rand(1); st_lat[0] = 1; st_lat[1] = 0;
      launch(2'b11);
      wait_done();
    end
    stage_rand(1); st_lat[1] = 2;
    launch(2'b10);
    wait_done();
    stage_rand(0); stage_rand(1);
    launch(2'b11);
    wait_done();

    // Master 0 abandons its request mid-BUSY; the pointer must not move.
    p.lat = 99; p.rdata = '0; p.err = 1'b0;
    plan_q.push_back(p);
    skip_busy = 1'b1;
    m_addr[0 +: AW] = 32'h0C20_0004;
    m_write[0] = 1'b0;
    m_valid[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_valid[0] = 1'b0;
    @(negedge clk);
    chk("drop_busy", 32'(busy_o), 1);
    chk("drop_slv_valid", 32'(slv_valid_o), 0);
    chk("drop_ready", 32'(mst_ready_o), 0);
    @(posedge clk); #1;
    chk("drop_idle", 32'(busy_o), 0);
    plan_q.delete();
    skip_busy = 1'b0;
    stage_rand(0); stage_rand(1);
    launch(2'b11);
    wait_done();

    // Timeout on master 0, slave error on a write from master 1.
    stage(0, 1'b0, 32'h0C20_0004, 32'h0, 4'h0, 99, 32'h0, 1'b0);
    launch(2'b01);
    wait_done();
    stage(1, 1'b1, 32'h0C00_2000, 32'h1, 4'hF, 1, 32'h0, 1'b1);
    launch(2'b10);
    wait_done();

    // Reset in the middle of a BUSY transaction.
    stage(0, 1'b0, 32'h0C00_1000, 32'h0, 4'h0, 1, 32'h1234, 1'b0);
    launch(2'b01);
    wait_done();
    stage(1, 1'b0, 32'h0C20_1004, 32'h0, 4'h0, 99, 32'h0, 1'b0);
    launch(2'b10);
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("pre_reset_busy", 32'(slv_valid_o), 1);
    rst = 1'b1;
    m_valid = '0;
    exp_q.delete();
    plan_q.delete();
    model_ptr = 0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    #1;
    check_all_zero("async_reset");
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    stage_rand(0); stage_rand(1);
    launch(2'b11);
    wait_done();

    // Randomized traffic.
    repeat (60) begin
      logic [N-1:0] mask;
      mask = N'($urandom_range(1, 3));
      for (int i = 0; i < N; i++) stage_rand(i);
      launch(mask);
      wait_done();
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
